// File: rtl/asrt_ctrl_pkg.sv
// Shared types for the assertion-control scheduler: control codes, mask encodings,
// the queued command record and the scheduler FSM states.
package asrt_ctrl_pkg;

  typedef enum logic [3:0] {
    CTRL_LOCK   = 4'd1,
    CTRL_UNLOCK = 4'd2,
    CTRL_ON     = 4'd3,
    CTRL_OFF    = 4'd4,
    CTRL_KILL   = 4'd5
  } ctrl_e;

  // Assertion-type bits of amask; deferred immediates occupy two adjacent bits.
  typedef enum logic [7:0] {
    AT_CONC     = 8'h01,
    AT_S_IMM    = 8'h02,
    AT_D_IMM    = 8'h0C,
    AT_EXPECT   = 8'h10,
    AT_UNIQUE   = 8'h20,
    AT_UNIQUE0  = 8'h40,
    AT_PRIORITY = 8'h80
  } atype_e;

  typedef enum logic [2:0] {
    DT_ASSERT = 3'b001,
    DT_COVER  = 3'b010,
    DT_ASSUME = 3'b100
  } dtype_e;

  localparam logic [7:0] ALL_ASSERTS    = 8'hFF;
  localparam logic [2:0] ALL_DIRECTIVES = 3'b111;

  // Queue entries carry a fixed-width delay; the top uses only its low DLY_W bits.
  localparam int unsigned CMD_DLY_W = 32;

  typedef struct packed {
    logic [CMD_DLY_W-1:0] delay;
    logic [3:0]           ctrl;
    logic [7:0]           amask;
    logic [2:0]           dmask;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE
  } state_e;

  function automatic logic ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_LOCK, CTRL_UNLOCK, CTRL_ON, CTRL_OFF, CTRL_KILL: ctrl_legal = 1'b1;
      default:                                              ctrl_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] expand_amask(input logic [7:0] amask);
    return (amask == '0) ? ALL_ASSERTS : amask;
  endfunction

  function automatic logic [2:0] expand_dmask(input logic [2:0] dmask);
    return (dmask == '0) ? ALL_DIRECTIVES : dmask;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock command FIFO; pointers carry one wrap bit to tell full from empty.
module sync_fifo
  import asrt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en_i,
  input  cmd_t wr_data_i,
  input  logic rd_en_i,
  output cmd_t rd_data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  cmd_t           mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           wr_fire;
  logic           rd_fire;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign wr_fire = wr_en_i && !full_o;
  assign rd_fire = rd_en_i && !empty_o;

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/assert_ctrl_sched.sv
// Timed scheduler for assertion-control commands: queues host commands, releases each
// after its delay over valid/ready, and mirrors per-type enable/lock state.
module assert_ctrl_sched
  import asrt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DLY_W-1:0] cmd_delay,
  input  logic [3:0]       cmd_ctrl,
  input  logic [7:0]       cmd_amask,
  input  logic [2:0]       cmd_dmask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_ctrl,
  output logic [7:0]       out_amask,
  output logic [2:0]       out_dmask,
  output logic [7:0]       en_mask,
  output logic [7:0]       lock_mask,
  output logic             kill_pulse,
  output logic             illegal_err,
  output logic             busy
);

  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  state_e           state_q;
  logic [DLY_W-1:0] cnt_q;
  logic             out_valid_q;
  logic [3:0]       work_ctrl_q;
  logic [7:0]       work_amask_q;
  logic [2:0]       work_dmask_q;
  logic [7:0]       en_q, en_d;
  logic [7:0]       lock_q, lock_d;
  logic             kill_q, kill_d;
  logic             illegal_q;
  logic [7:0]       eff_mask;
  logic             issue_hs;

  always_comb begin
    push_cmd.delay = CMD_DLY_W'(cmd_delay);
    push_cmd.ctrl  = cmd_ctrl;
    push_cmd.amask = cmd_amask;
    push_cmd.dmask = cmd_dmask;
  end

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (cmd_valid),
    .wr_data_i (push_cmd),
    .rd_en_i   (fifo_pop),
    .rd_data_o (head_cmd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
  assign issue_hs  = out_valid_q && out_ready;

  // Locks are judged against the pre-update lock state, so a LOCK never masks itself.
  assign eff_mask = work_amask_q & ~lock_q;

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    en_d   = en_q;
    lock_d = lock_q;
    kill_d = 1'b0;
    if (issue_hs) begin
      case (work_ctrl_q)
        CTRL_ON:     en_d   = en_q | eff_mask;
        CTRL_OFF:    en_d   = en_q & ~eff_mask;
        CTRL_LOCK:   lock_d = lock_q | work_amask_q;
        CTRL_UNLOCK: lock_d = lock_q & ~work_amask_q;
        CTRL_KILL:   kill_d = |eff_mask;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      work_ctrl_q  <= '0;
      work_amask_q <= '0;
      work_dmask_q <= '0;
      en_q         <= ALL_ASSERTS;
      lock_q       <= '0;
      kill_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      en_q   <= en_d;
      lock_q <= lock_d;
      kill_q <= kill_d;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (!ctrl_legal(head_cmd.ctrl)) begin
              illegal_q <= 1'b1;
            end else begin
              work_ctrl_q  <= head_cmd.ctrl;
              work_amask_q <= expand_amask(head_cmd.amask);
              work_dmask_q <= expand_dmask(head_cmd.dmask);
              if (head_cmd.delay == '0) begin
                state_q     <= ST_ISSUE;
                out_valid_q <= 1'b1;
              end else begin
                cnt_q   <= head_cmd.delay[DLY_W-1:0];
                state_q <= ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          // cnt is loaded with a non-zero delay, so it reaches 1 before it could wrap.
          cnt_q <= cnt_q - DLY_W'(1);
          if (cnt_q == DLY_W'(1)) begin
            state_q     <= ST_ISSUE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_ctrl    = work_ctrl_q;
  assign out_amask   = work_amask_q;
  assign out_dmask   = work_dmask_q;
  assign en_mask     = en_q;
  assign lock_mask   = lock_q;
  assign kill_pulse  = kill_q;
  assign illegal_err = illegal_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_assert_ctrl_sched.sv
// Self-checking bench for assert_ctrl_sched: directed latency/mirror scenarios plus
// randomized traffic scored against an in-order command model with its own mirror.
module tb_assert_ctrl_sched;

  localparam int DEPTH = 4;
  localparam int DLY_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [DLY_W-1:0] cmd_delay;
  logic [3:0]       cmd_ctrl;
  logic [7:0]       cmd_amask;
  logic [2:0]       cmd_dmask;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_ctrl;
  logic [7:0]       out_amask;
  logic [2:0]       out_dmask;
  logic [7:0]       en_mask;
  logic [7:0]       lock_mask;
  logic             kill_pulse;
  logic             illegal_err;
  logic             busy;

  always #5 clk = ~clk;

  assert_ctrl_sched #(
    .DEPTH (DEPTH),
    .DLY_W (DLY_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_delay   (cmd_delay),
    .cmd_ctrl    (cmd_ctrl),
    .cmd_amask   (cmd_amask),
    .cmd_dmask   (cmd_dmask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_amask   (out_amask),
    .out_dmask   (out_dmask),
    .en_mask     (en_mask),
    .lock_mask   (lock_mask),
    .kill_pulse  (kill_pulse),
    .illegal_err (illegal_err),
    .busy        (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: commands in push order, plus the mirror the issues should produce.
  typedef struct {
    int unsigned dly;
    logic [3:0]  c;
    logic [7:0]  a;
    logic [2:0]  d;
  } mcmd_t;

  mcmd_t       sb_q[$];
  logic [7:0]  m_en      = 8'hFF;
  logic [7:0]  m_lock    = 8'h00;
  bit          m_kill    = 1'b0;
  bit          m_illegal = 1'b0;
  bit          stall     = 1'b0;
  logic [14:0] stall_val;

  function automatic bit is_legal(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd5);
  endfunction

  task automatic model_issue();
    mcmd_t      m;
    logic [7:0] a;
    logic [7:0] eff;
    logic [2:0] d;
    while (sb_q.size() > 0 && !is_legal(sb_q[0].c)) begin
      void'(sb_q.pop_front());
      m_illegal = 1'b1;
    end
    check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() == 0) return;
    m = sb_q.pop_front();
    a = (m.a == 8'h00) ? 8'hFF : m.a;
    d = (m.d == 3'b000) ? 3'b111 : m.d;
    check("issue_cmd", {17'd0, out_ctrl, out_amask, out_dmask}, {17'd0, m.c, a, d});
    eff = a & ~m_lock;
    case (m.c)
      4'd1: m_lock = m_lock | a;
      4'd2: m_lock = m_lock & ~a;
      4'd3: m_en   = m_en | eff;
      4'd4: m_en   = m_en & ~eff;
      4'd5: m_kill = (eff != 8'h00);
      default: ;
    endcase
  endtask

  // Monitor samples on the falling edge, half a cycle away from every register update.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_en      = 8'hFF;
      m_lock    = 8'h00;
      m_kill    = 1'b0;
      m_illegal = 1'b0;
      stall     = 1'b0;
    end else begin
      check("kill_pulse", 32'(kill_pulse), 32'(m_kill));
      check("en_mask", 32'(en_mask), 32'(m_en));
      check("lock_mask", 32'(lock_mask), 32'(m_lock));
      if (stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", {17'd0, out_ctrl, out_amask, out_dmask}, {17'd0, stall_val});
      end
      m_kill    = 1'b0;
      stall     = out_valid && !out_ready;
      stall_val = {out_ctrl, out_amask, out_dmask};
      if (out_valid && out_ready) model_issue();
      if (cmd_valid && cmd_ready) begin
        mcmd_t m;
        m.dly = int'(cmd_delay);
        m.c   = cmd_ctrl;
        m.a   = cmd_amask;
        m.d   = cmd_dmask;
        sb_q.push_back(m);
      end
    end
  end

  // out_ready source: 0 = hold off, 1 = always ready, 2 = random back-pressure.
  int rdy_mode = 1;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  logic [3:0] cap_ctrl;
  logic [7:0] cap_amask;
  logic [2:0] cap_dmask;

  // Called #1 after a rising edge; returns #1 after the edge that accepted the command.
  task automatic push(input int unsigned d, input logic [3:0] c, input logic [7:0] a,
                      input logic [2:0] dm);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_delay = d[DLY_W-1:0];
    cmd_ctrl  = c;
    cmd_amask = a;
    cmd_dmask = dm;
    for (int i = 0; i < 500 && !acc; i++) begin
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (!acc) check("push_timeout", 32'(acc), 32'd1);
  endtask

  // Push one command with out_ready high, measure cycles from the accept cycle to
  // out_valid, then step past the issue handshake.
  task automatic run_cmd(input int unsigned d, input logic [3:0] c, input logic [7:0] a,
                         input logic [2:0] dm, input int exp_lat, input string tag);
    int lat;
    push(d, c, a, dm);
    lat = 1;
    while (!out_valid && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    cap_ctrl  = out_ctrl;
    cap_amask = out_amask;
    cap_dmask = out_dmask;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_drain(input string tag);
    while (sb_q.size() > 0 && !is_legal(sb_q[0].c)) begin
      void'(sb_q.pop_front());
      m_illegal = 1'b1;
    end
    check({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_illegal"}, 32'(illegal_err), 32'(m_illegal));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 5000 && (busy || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_idle"}, 32'(busy || out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_v;
    int second_v;
    int pushed;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_delay = '0;
    cmd_ctrl  = '0;
    cmd_amask = '0;
    cmd_dmask = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("rst_en_mask", 32'(en_mask), 32'hFF);
    check("rst_lock_mask", 32'(lock_mask), 32'h00);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {17'd0, out_ctrl, out_amask, out_dmask}, 32'd0);
    check("rst_flags", {30'd0, kill_pulse, illegal_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // OFF with zero masks: defaults expand, issue two cycles after accept
    run_cmd(0, 4'd4, 8'h00, 3'b000, 2, "t2");
    check("t2_amask", 32'(cap_amask), 32'hFF);
    check("t2_dmask", 32'(cap_dmask), 32'h7);
    check("t2_en", 32'(en_mask), 32'h00);

    // ON with delay 20
    run_cmd(20, 4'd3, 8'h07, 3'b001, 22, "t3");
    check("t3_ctrl", 32'(cap_ctrl), 32'd3);
    check("t3_en", 32'(en_mask), 32'h07);

    // Lock shields bit0 from ON
    run_cmd(0, 4'd4, 8'h07, 3'b000, 2, "t4off");
    check("t4_en0", 32'(en_mask), 32'h00);
    run_cmd(0, 4'd1, 8'h01, 3'b000, 2, "t4lock");
    check("t4_lock", 32'(lock_mask), 32'h01);
    run_cmd(0, 4'd3, 8'hFF, 3'b000, 2, "t4on");
    run_cmd(0, 4'd2, 8'h01, 3'b000, 2, "t4unlock");
    check("t4_en", 32'(en_mask), 32'hFE);
    check("t4_lock_clr", 32'(lock_mask), 32'h00);

    // Smallest non-zero delay
    run_cmd(1, 4'd3, 8'h01, 3'b000, 3, "dly1");
    check("dly1_en", 32'(en_mask), 32'hFF);

    // KILL only pulses when some targeted type is unlocked
    run_cmd(0, 4'd1, 8'h01, 3'b000, 2, "t5lock");
    run_cmd(0, 4'd5, 8'h01, 3'b000, 2, "t5kill_l");
    check("t5_kill_locked", 32'(kill_pulse), 32'd0);
    run_cmd(0, 4'd2, 8'h01, 3'b000, 2, "t5unlock");
    run_cmd(0, 4'd5, 8'h01, 3'b000, 2, "t5kill");
    check("t5_kill_pulse", 32'(kill_pulse), 32'd1);
    check("t5_en_kept", 32'(en_mask), 32'hFF);
    @(posedge clk);
    #1;
    check("t5_kill_single", 32'(kill_pulse), 32'd0);

    // Back-to-back delay-0 commands issue two cycles apart
    push(0, 4'd4, 8'h02, 3'b000);
    push(0, 4'd3, 8'h02, 3'b000);
    first_v  = -1;
    second_v = -1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        else if (second_v < 0) second_v = i;
      end
      @(posedge clk);
      #1;
    end
    check("b2b_first", 32'(first_v), 32'd0);
    check("b2b_gap", 32'(second_v - first_v), 32'd2);

    // Fill the FIFO behind a stalled issue
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    pushed = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(0, 4'd3, 8'(8'h10 << (i % 4)), 3'(i + 1));
      pushed++;
    end
    check("t6_pushed", 32'(pushed), 32'(DEPTH + 1));
    check("t6_full", 32'(cmd_ready), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_valid", 32'(out_valid), 32'd1);
    cmd_valid = 1'b1;
    cmd_ctrl  = 4'd4;
    cmd_amask = 8'hFF;
    cmd_delay = '0;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("t6_still_full", 32'(cmd_ready), 32'd0);
    rdy_mode = 1;
    wait_idle("t6");

    // Illegal control is flagged and never forwarded
    push(0, 4'd9, 8'h01, 3'b001);
    run_cmd(0, 4'd4, 8'h10, 3'b000, -1, "t6legal");
    check("t6_legal_ctrl", 32'(cap_ctrl), 32'd4);
    check("t6_illegal_err", 32'(illegal_err), 32'd1);
    sb_drain("t6");

    // Reset in the middle of a long wait
    run_cmd(0, 4'd1, 8'h80, 3'b000, 2, "t6lock");
    push(100, 4'd4, 8'hFF, 3'b000);
    repeat (10) @(posedge clk);
    #1;
    check("t6_wait_busy", 32'(busy), 32'd1);
    check("t6_wait_novalid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    #2;
    check("t6_rst_en", 32'(en_mask), 32'hFF);
    check("t6_rst_lock", 32'(lock_mask), 32'h00);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(cmd_ready), 32'd1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_illegal", 32'(illegal_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("t6_dropped", 32'(out_valid), 32'd0);

    // Random traffic with random back-pressure
    rdy_mode = 2;
    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      int unsigned d;
      logic [3:0]  c;
      logic [7:0]  a;
      logic [2:0]  dm;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      r = $urandom_range(0, 15);
      if (r < 12) c = 4'(1 + r % 5);
      else if (r == 12) c = 4'd0;
      else c = 4'(r - 6);
      a  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      dm = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : $urandom_range(0, 2);
      push(d, c, a, dm);
    end
    rdy_mode = 1;
    wait_idle("rand");
    repeat (2) @(posedge clk);
    #1;
    sb_drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
